// File: rtl/core_seq_if.sv
// Memory and fence handshake bundle between the RV32I sequencer and its memory/drain agents.
// The sequencer side (master) raises requests; the agents (slave) answer with acks and fetch data.
interface core_seq_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic            fence_req;
    logic            fence_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, fence_req,
        input  imem_ack, imem_rdata, dmem_ack, fence_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, fence_req,
        output imem_ack, imem_rdata, dmem_ack, fence_ack
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: owns PC and instruction register, steps each instruction
// through fetch/decode/exec/mem/fence/writeback and counts retired instructions.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | imem_req high at pc, latch inst on imem_ack
// S_DECODE | one cycle for CtrlUnit flags to settle on the new inst
// S_EXEC   | capture branch/jump decision and target, pick next phase
// S_MEM    | dmem_req high (we = is_store) until dmem_ack
// S_FENCE  | fence_req high until fence_ack
// S_WB     | rf_we/retire pulse, pc and instret update
// S_HALT   | misaligned taken target; frozen until reset, trap high
module core_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    core_seq_if.master      bus,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_branch,
    input  logic            is_jmp,
    input  logic            is_fence,
    input  logic            is_fencei,
    input  logic            rd_w,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] target,
    output logic            rf_we,
    output logic            retire,
    output logic [63:0]     instret,
    output logic            trap
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_FENCE  = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            take_q, take_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [63:0]     instret_q, instret_d;
    logic            trap_q, trap_d;
    logic            misaligned;

    // Jumps ignore target[0] (jalr clears it); branches must be fully halfword-clean too.
    assign misaligned = target[1] | (~is_jmp & target[0]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        take_d    = take_q;
        target_d  = target_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    inst_d  = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                take_d   = is_jmp | (is_branch & branch_taken);
                target_d = target;
                if (take_d && misaligned) begin
                    trap_d  = 1'b1;
                    state_d = S_HALT;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_fence || is_fencei) begin
                    state_d = S_FENCE;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.dmem_ack) state_d = S_WB;
            end
            S_FENCE: begin
                if (bus.fence_ack) state_d = S_WB;
            end
            S_WB: begin
                pc_d      = take_q ? {target_q[XLEN-1:1], 1'b0} : pc_q + XLEN'(4);
                instret_d = instret_q + 64'd1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            take_q    <= 1'b0;
            target_q  <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            take_q    <= take_d;
            target_q  <= target_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end

    // Outputs are gated by rst so requests drop the instant reset asserts, not at the next edge.
    assign bus.imem_req  = ~rst & (state_q == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = ~rst & (state_q == S_MEM);
    assign bus.dmem_we   = ~rst & (state_q == S_MEM) & is_store;
    assign bus.fence_req = ~rst & (state_q == S_FENCE);
    assign rf_we         = ~rst & (state_q == S_WB) & rd_w & ~is_store & ~is_branch;
    assign retire        = ~rst & (state_q == S_WB);

    assign inst    = inst_q;
    assign pc      = pc_q;
    assign instret = instret_q;
    assign trap    = trap_q;
endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: stimulus pushes expected writeback results into a queue,
// a monitor pops and checks them on every retire pulse.
module tb_core_seq;
    localparam int NORMAL = 0;
    localparam int TRAP   = 1;
    localparam int ABORT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, pc, target;
    logic        is_load, is_store, is_branch, is_jmp, is_fence, is_fencei, rd_w, branch_taken;
    logic        rf_we, retire, trap;
    logic [63:0] instret;

    always #5 clk = ~clk;

    core_seq_if #(.XLEN(32)) bus_if ();

    core_seq #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .inst         (inst),
        .pc           (pc),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_branch    (is_branch),
        .is_jmp       (is_jmp),
        .is_fence     (is_fence),
        .is_fencei    (is_fencei),
        .rd_w         (rd_w),
        .branch_taken (branch_taken),
        .target       (target),
        .rf_we        (rf_we),
        .retire       (retire),
        .instret      (instret),
        .trap         (trap)
    );

    typedef struct {
        logic        rfwe;
        logic [31:0] pc;
        logic [63:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_ret;
    logic [31:0] exp_inst;
    logic [31:0] cur_pc;
    logic        stray;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_flags();
        is_load = 0; is_store = 0; is_branch = 0; is_jmp = 0;
        is_fence = 0; is_fencei = 0; rd_w = 0; branch_taken = 0; target = '0;
    endtask

    // Monitor: every retire pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_retire: got retire with empty queue at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("wb_rf_we", rf_we, e.rfwe);
                    @(posedge clk);
                    #1;
                    chk("wb_pc", pc, e.pc);
                    chk("wb_instret", instret, e.ret);
                end
            end
        end
    end

    task automatic run(input string nm, input int mode, input logic [31:0] instr,
                       input logic ld, st, br, jp, fn, fi, rdw, tk, input logic [31:0] tgt,
                       input int iw, dw, fw, input logic [31:0] exp_pc, input logic exp_rfwe);
        exp_t e;
        if (mode == NORMAL) begin
            exp_ret  = exp_ret + 64'd1;
            e.rfwe   = exp_rfwe;
            e.pc     = exp_pc;
            e.ret    = exp_ret;
            sb.push_back(e);
        end
        for (int i = 0; i <= iw; i++) begin
            @(negedge clk);
            if (i == 0) begin
                is_load = ld; is_store = st; is_branch = br; is_jmp = jp;
                is_fence = fn; is_fencei = fi; rd_w = rdw; branch_taken = tk; target = tgt;
            end
            chk({nm, "_imem_req"}, bus_if.imem_req, 1'b1);
            chk({nm, "_imem_addr"}, bus_if.imem_addr, cur_pc);
            chk({nm, "_inst_hold"}, inst, exp_inst);
            bus_if.imem_ack   = (i == iw);
            bus_if.imem_rdata = instr;
            bus_if.dmem_ack   = stray && (i < iw);
            bus_if.fence_ack  = stray && (i < iw);
        end
        @(negedge clk);
        bus_if.imem_ack  = 0;
        bus_if.dmem_ack  = 0;
        bus_if.fence_ack = 0;
        exp_inst = instr;
        chk({nm, "_inst"}, inst, exp_inst);
        @(negedge clk);
        if (mode == TRAP) begin
            @(negedge clk);
            chk({nm, "_trap"}, trap, 1'b1);
            chk({nm, "_halt_reqs"}, {bus_if.imem_req, bus_if.dmem_req, bus_if.fence_req, rf_we, retire}, 5'b0);
            repeat (10) begin
                @(negedge clk);
                chk({nm, "_halt_pc"}, pc, cur_pc);
                chk({nm, "_halt_instret"}, instret, exp_ret);
                chk({nm, "_halt_imem_req"}, bus_if.imem_req, 1'b0);
            end
            return;
        end
        if (ld || st) begin
            for (int j = 0; j <= dw; j++) begin
                @(negedge clk);
                chk({nm, "_dmem_req"}, bus_if.dmem_req, 1'b1);
                chk({nm, "_dmem_we"}, bus_if.dmem_we, st);
                chk({nm, "_mem_rf_we"}, rf_we, 1'b0);
                if (mode == ABORT && j == 1) begin
                    #2 rst = 1;
                    #1;
                    chk({nm, "_rst_dmem_req"}, bus_if.dmem_req, 1'b0);
                    chk({nm, "_rst_imem_req"}, bus_if.imem_req, 1'b0);
                    chk({nm, "_rst_pc"}, pc, 32'h0);
                    chk({nm, "_rst_instret"}, instret, 64'h0);
                    chk({nm, "_rst_inst"}, inst, 32'h0000_0013);
                    clear_flags();
                    @(negedge clk);
                    rst = 0;
                    exp_ret  = 0;
                    exp_inst = 32'h0000_0013;
                    cur_pc   = 32'h0;
                    #1 chk({nm, "_rel_imem_req"}, bus_if.imem_req, 1'b1);
                    return;
                end
                bus_if.dmem_ack = (j == dw);
            end
        end else if (fn || fi) begin
            for (int j = 0; j <= fw; j++) begin
                @(negedge clk);
                chk({nm, "_fence_req"}, bus_if.fence_req, 1'b1);
                chk({nm, "_fence_retire"}, retire, 1'b0);
                bus_if.fence_ack = (j == fw);
            end
        end
        @(negedge clk);
        bus_if.dmem_ack  = 0;
        bus_if.fence_ack = 0;
        chk({nm, "_wb_reqs"}, {bus_if.imem_req, bus_if.dmem_req, bus_if.fence_req}, 3'b0);
        cur_pc = exp_pc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        stray = 0;
        clear_flags();
        bus_if.imem_ack = 0; bus_if.imem_rdata = '0;
        bus_if.dmem_ack = 0; bus_if.fence_ack = 0;
        exp_ret = 0; exp_inst = 32'h0000_0013; cur_pc = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_imem_req", bus_if.imem_req, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_instret", instret, 64'h0);
        chk("rst_trap", trap, 1'b0);
        @(negedge clk);
        rst = 0;
        #1 chk("rel_imem_req", bus_if.imem_req, 1'b1);

        //   name       mode    instr         ld st br jp fn fi rdw tk target        iw dw fw exp_pc        rfwe
        run("addi0",   NORMAL, 32'h00100093, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 32'h4,        1);
        stray = 1;
        run("addi_w3", NORMAL, 32'h00208113, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        3, 0, 0, 32'h8,        1);
        stray = 0;
        run("sw",      NORMAL, 32'h0020a423, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0,        0, 2, 0, 32'hC,        0);
        run("beq_t",   NORMAL, 32'h02000a63, 0, 0, 1, 0, 0, 0, 1, 1, 32'h40,       0, 0, 0, 32'h40,       0);
        run("beq_nt",  NORMAL, 32'h02000063, 0, 0, 1, 0, 0, 0, 0, 0, 32'h80,       0, 0, 0, 32'h44,       0);
        run("jalr",    NORMAL, 32'h000080e7, 0, 0, 0, 1, 0, 0, 1, 0, 32'h81,       0, 0, 0, 32'h80,       1);
        run("lw",      NORMAL, 32'h0000a183, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 32'h84,       1);
        run("fence",   NORMAL, 32'h0ff0000f, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 4, 32'h88,       0);
        run("sw_abrt", ABORT,  32'h0020a423, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 0, 32'h0,        0);
        run("fencei",  NORMAL, 32'h0000100f, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h4,        0);
        run("jalr_hi", NORMAL, 32'hffd080e7, 0, 0, 0, 1, 0, 0, 1, 0, 32'hFFFFFFFD, 0, 0, 0, 32'hFFFFFFFC, 1);
        run("addi_wr", NORMAL, 32'h00100093, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        1, 0, 0, 32'h0,        1);
        run("jal_mis", TRAP,   32'h042000ef, 0, 0, 0, 1, 0, 0, 1, 0, 32'h42,       0, 0, 0, 32'h0,        0);

        @(negedge clk);
        rst = 1;
        clear_flags();
        #1;
        chk("trap_rst_trap", trap, 1'b0);
        chk("trap_rst_pc", pc, 32'h0);
        chk("trap_rst_instret", instret, 64'h0);
        @(negedge clk);
        rst = 0;
        exp_ret = 0; exp_inst = 32'h0000_0013; cur_pc = 0;
        run("addi_rec", NORMAL, 32'h00100093, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,      0, 0, 0, 32'h4,        1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
